l1_cache_control: RTL and testbench
===================================

Name: l1_cache_control

Overview:
- Control FSM for the 2-way set-associative, write-back L1 cache built from two cache_way instances: 8 sets, 9-bit tag, 128-bit line, 16-bit byte address.
- Decides hit/miss from the ways' V/tag outputs and keeps per-set LRU state.
- Sequences victim writeback and line fill over the physical-memory handshake.
- Drives way write enables, dirty-in and the data-source select for the external cache datapath.

Parameters:
- TAG_BITS, 9, tag width (address[15:7])
- INDEX_BITS, 3, set index width (address[6:4]); sets = 2**INDEX_BITS
- OFFSET_BITS, 4, byte offset in 128-bit line (address[3:0])

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_address  in  16  CPU byte address, held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to CPU
- v0, v1  in  1  valid out of way0/way1 at current index
- d0, d1  in  1  dirty out of way0/way1 at current index
- tag0, tag1  in  TAG_BITS  tag out of way0/way1 at current index
- way_ix  out  INDEX_BITS  index to both ways (= mem_address[6:4])
- we0, we1  out  1  way write enables
- d_in  out  1  dirty bit written with the line
- fill_sel  out  1  datapath line source: 0 = CPU-merged line, 1 = pmem line
- out_way  out  1  way steering CPU read data / writeback data
- pmem_read  out  1  line read request
- pmem_write  out  1  line write request
- pmem_address  out  16  line address, low OFFSET_BITS zero
- pmem_resp  in  1  pmem done, one-cycle pulse

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset state: FSM=IDLE; lru[all]=0. All outputs 0 except way_ix, which follows mem_address.
- Reset mid-operation: pmem strobes drop the cycle after rst is sampled; no we pulse; the pending request is dropped. Way contents are untouched.
- Derived signals: hitN = vN && tagN==mem_address[15:7]; hit = hit0|hit1. A write is mem_write. If mem_read and mem_write are both high, the access is a write.
- IDLE: on mem_read|mem_write, go to CHECK. No outputs asserted.
- CHECK, hit:
  - mem_resp=1 this cycle; out_way=hit1.
  - On a write: we of the hit way=1, d_in=1, fill_sel=0.
  - lru[idx] <= hit0 (points to the way not used).
  - Next state IDLE.
  - Hit latency is 2 cycles from the request (IDLE, CHECK).
- CHECK, miss, victim selection:
  - victim = 0 if !v0; else 1 if !v1; else lru[idx]. Victim is registered.
  - If the victim is valid and dirty, go to WB; otherwise go to FILL.
- WB:
  - pmem_write=1; pmem_address={victim tag, idx, 4'h0}; out_way=victim.
  - Hold all of these until pmem_resp, then go to FILL.
- FILL:
  - pmem_read=1; pmem_address={mem_address[15:4], 4'h0}.
  - On pmem_resp: we(victim)=1, d_in=0, fill_sel=1; go to CHECK.
  - The re-check hits and completes the access (write then sets dirty).
- LRU: updated only on a hit in CHECK, never by FILL.
- Strobe timing: pmem strobes and pmem_address are registered and stable while waiting. At most one of pmem_read/pmem_write is high. we0 and we1 are never both high.
- mem_resp is never asserted in WB or FILL. The CPU must not change its request before mem_resp; if it does, behaviour is undefined.
- Back-to-back requests: the next request is seen in IDLE the cycle after mem_resp.

Optional Feature:
- Macro: L1_PERF_CNT_EN.
- Defined: adds outputs hit_count[15:0] and miss_count[15:0], both cleared by rst.
  - hit_count increments on a CHECK hit that is not the re-check after a FILL.
  - miss_count increments on each first-CHECK miss.
  - Both saturate at 16'hFFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Cold read 16'h1230, ways invalid -> FILL with pmem_address 16'h1230, we0 on pmem_resp, d_in=0. Re-check hit -> mem_resp; lru[3]=1.
- Read hit 16'h1234 after the above -> mem_resp exactly 2 cycles after request, no pmem activity, out_way=0.
- Write hit 16'h1238 -> we0=1, d_in=1, fill_sel=0 in the mem_resp cycle.
- Set 3: way0 tag 9'h024 dirty, way1 valid, lru[3]=0. Read 16'hA030 -> WB with pmem_address 16'h1230, then FILL 16'hA030, we0, then mem_resp.
- Assert rst in WB while pmem_resp is withheld -> next cycle pmem_write=0, state IDLE, lru cleared, no mem_resp.
- With L1_PERF_CNT_EN: 1 cold miss + 3 hits -> miss_count=1, hit_count=3.

Source files
------------

// File: rtl/l1_cache_control.sv
`default_nettype none
// ============================================================================
// Module   : l1_cache_control
// Purpose  : Control FSM for a 2-way set-associative write-back L1 cache.
//            Resolves hit/miss from the way V/tag outputs, keeps per-set LRU,
//            sequences victim writeback and line fill on the pmem handshake.
// Options  : L1_PERF_CNT_EN adds saturating hit_count / miss_count outputs.
// Revision : 1.0  initial release
// ============================================================================
module l1_cache_control #(
    parameter int TAG_BITS    = 9,
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     mem_read,
    input  logic                                     mem_write,
    input  logic [TAG_BITS+INDEX_BITS+OFFSET_BITS-1:0] mem_address,
    output logic                                     mem_resp,
    input  logic                                     v0,
    input  logic                                     v1,
    input  logic                                     d0,
    input  logic                                     d1,
    input  logic [TAG_BITS-1:0]                      tag0,
    input  logic [TAG_BITS-1:0]                      tag1,
    output logic [INDEX_BITS-1:0]                    way_ix,
    output logic                                     we0,
    output logic                                     we1,
    output logic                                     d_in,
    output logic                                     fill_sel,
    output logic                                     out_way,
    output logic                                     pmem_read,
    output logic                                     pmem_write,
    output logic [TAG_BITS+INDEX_BITS+OFFSET_BITS-1:0] pmem_address,
    input  logic                                     pmem_resp
`ifdef L1_PERF_CNT_EN
    ,
    output logic [15:0]                              hit_count,
    output logic [15:0]                              miss_count
`endif
);

    localparam int ADDR_BITS = TAG_BITS + INDEX_BITS + OFFSET_BITS;
    localparam int SETS      = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_WB    = 2'd2,
        S_FILL  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SETS-1:0]        r_lru;
    logic                   r_victim;
    logic                   r_pmem_read;
    logic                   r_pmem_write;
    logic [ADDR_BITS-1:0]   r_pmem_address;

    logic [TAG_BITS-1:0]    w_tag;
    logic [INDEX_BITS-1:0]  w_idx;
    logic                   w_hit0;
    logic                   w_hit1;
    logic                   w_hit;
    logic                   w_victim;
    logic                   w_victim_dirty;
    logic [TAG_BITS-1:0]    w_victim_tag;
    logic [ADDR_BITS-1:0]   w_fill_address;
    logic                   w_lru_upd;
    logic                   w_unused_offset;

    assign w_tag          = mem_address[ADDR_BITS-1 -: TAG_BITS];
    assign w_idx          = mem_address[OFFSET_BITS +: INDEX_BITS];
    assign w_hit0         = v0 && (tag0 == w_tag);
    assign w_hit1         = v1 && (tag1 == w_tag);
    assign w_hit          = w_hit0 | w_hit1;
    // Empty way first, otherwise the least recently used one.
    assign w_victim       = !v0 ? 1'b0 : (!v1 ? 1'b1 : r_lru[w_idx]);
    assign w_victim_dirty = w_victim ? (v1 && d1) : (v0 && d0);
    assign w_victim_tag   = w_victim ? tag1 : tag0;
    assign w_fill_address = {mem_address[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign w_unused_offset = &{1'b0, mem_address[OFFSET_BITS-1:0]};

    assign way_ix       = w_idx;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;

    // Next-state and per-state strobes; everything is silenced while rst is high.
    always_comb begin
        w_next    = r_state;
        mem_resp  = 1'b0;
        we0       = 1'b0;
        we1       = 1'b0;
        d_in      = 1'b0;
        fill_sel  = 1'b0;
        out_way   = 1'b0;
        w_lru_upd = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_read || mem_write) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_hit) begin
                    mem_resp  = 1'b1;
                    out_way   = w_hit1;
                    w_lru_upd = 1'b1;
                    if (mem_write) begin
                        we0  = w_hit0;
                        we1  = w_hit1 && !w_hit0;
                        d_in = 1'b1;
                    end
                    w_next = S_IDLE;
                end else begin
                    w_next = w_victim_dirty ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                out_way = r_victim;
                if (pmem_resp) w_next = S_FILL;
            end
            S_FILL: begin
                if (pmem_resp) begin
                    we0      = !r_victim;
                    we1      = r_victim;
                    fill_sel = 1'b1;
                    w_next   = S_CHECK;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (rst) begin
            mem_resp  = 1'b0;
            we0       = 1'b0;
            we1       = 1'b0;
            d_in      = 1'b0;
            fill_sel  = 1'b0;
            out_way   = 1'b0;
            w_lru_upd = 1'b0;
        end
    end

    // State, LRU, registered victim and registered pmem request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_lru          <= '0;
            r_victim       <= 1'b0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
        end else begin
            r_state <= w_next;
            if (w_lru_upd) r_lru[w_idx] <= w_hit0;
            if (r_state == S_CHECK && !w_hit) begin
                r_victim <= w_victim;
                if (w_victim_dirty) begin
                    r_pmem_write   <= 1'b1;
                    r_pmem_address <= {w_victim_tag, w_idx, {OFFSET_BITS{1'b0}}};
                end else begin
                    r_pmem_read    <= 1'b1;
                    r_pmem_address <= w_fill_address;
                end
            end else if (r_state == S_WB && pmem_resp) begin
                r_pmem_write   <= 1'b0;
                r_pmem_read    <= 1'b1;
                r_pmem_address <= w_fill_address;
            end else if (r_state == S_FILL && pmem_resp) begin
                r_pmem_read    <= 1'b0;
            end
        end
    end

`ifdef L1_PERF_CNT_EN
    logic r_refill;

    // Saturating counters; the re-check that follows a fill is not a new hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            r_refill   <= 1'b0;
        end else begin
            if (r_state == S_FILL && pmem_resp) r_refill <= 1'b1;
            else if (r_state == S_CHECK)        r_refill <= 1'b0;
            if (r_state == S_CHECK && !r_refill) begin
                if (w_hit && hit_count != 16'hFFFF)   hit_count  <= hit_count + 16'd1;
                if (!w_hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`else
    // Performance counters not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_l1_cache_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_cache_control
// Purpose  : Self-checking bench for l1_cache_control with behavioural ways,
//            a randomized pmem responder and an access-level cache model.
// Revision : 1.0  initial release
// ============================================================================
module tb_l1_cache_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, mem_resp;
    logic [15:0] mem_address;
    logic        v0, v1, d0, d1;
    logic [8:0]  tag0, tag1;
    logic [2:0]  way_ix;
    logic        we0, we1, d_in, fill_sel, out_way;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [15:0] pmem_address;
`ifdef L1_PERF_CNT_EN
    logic [15:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    l1_cache_control dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_resp(mem_resp),
        .v0(v0), .v1(v1), .d0(d0), .d1(d1), .tag0(tag0), .tag1(tag1),
        .way_ix(way_ix), .we0(we0), .we1(we1), .d_in(d_in),
        .fill_sel(fill_sel), .out_way(out_way),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address),
`ifdef L1_PERF_CNT_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .pmem_resp(pmem_resp)
    );

    // Behavioural cache ways: asynchronous read, write on the clock edge.
    logic [7:0] wv0 = '0, wv1 = '0, wd0 = '0, wd1 = '0;
    logic [8:0] wt0 [8];
    logic [8:0] wt1 [8];
    assign v0 = wv0[way_ix];  assign v1 = wv1[way_ix];
    assign d0 = wd0[way_ix];  assign d1 = wd1[way_ix];
    assign tag0 = wt0[way_ix]; assign tag1 = wt1[way_ix];
    always @(posedge clk) begin
        if (we0) begin wv0[way_ix] <= 1'b1; wd0[way_ix] <= d_in; wt0[way_ix] <= mem_address[15:7]; end
        if (we1) begin wv1[way_ix] <= 1'b1; wd1[way_ix] <= d_in; wt1[way_ix] <= mem_address[15:7]; end
    end

    // Access-level reference model of the cache contents.
    bit       mv [2][8];
    bit       md [2][8];
    bit [8:0] mt [2][8];
    bit       mlru [8];
    int       m_hit, m_miss;

    int errors = 0;
    int checks = 0;

    int          obs_lat, obs_fill_way, wb_n, fill_n;
    logic [15:0] obs_wb_a, obs_fill_a;
    logic [1:0]  obs_we;
    logic        obs_d, obs_sel, obs_way, obs_fill_d, obs_fill_sel;

    // Drive one CPU access, answer pmem with random latency, check against the model.
    task automatic do_access(input bit r, input bit w, input logic [15:0] a);
        bit [2:0]    s;
        bit [8:0]    t;
        int          hw, vic, exp_way;
        bit          exp_wb, got, proto, busy;
        logic [15:0] exp_wb_a, exp_fill_a, cur_a;
        logic [1:0]  exp_we;
        int          cnt, dly;
        s = a[6:4]; t = a[15:7]; hw = -1; vic = 0; exp_wb = 0; exp_wb_a = '0;
        for (int k = 0; k < 2; k++) if (mv[k][s] && mt[k][s] == t) hw = k;
        exp_fill_a = {a[15:4], 4'h0};
        if (hw < 0) begin
            vic      = !mv[0][s] ? 0 : (!mv[1][s] ? 1 : int'(mlru[s]));
            exp_wb   = mv[vic][s] && md[vic][s];
            exp_wb_a = {mt[vic][s], s, 4'h0};
            exp_way  = vic;
        end else exp_way = hw;
        exp_we = !w ? 2'b00 : (exp_way == 1 ? 2'b10 : 2'b01);

        got = 0; proto = 1; busy = 0; cnt = 0; dly = 0; cur_a = '0;
        wb_n = 0; fill_n = 0; obs_lat = 0; obs_fill_way = -1;
        obs_wb_a = '0; obs_fill_a = '0; obs_we = '0; obs_d = 0; obs_sel = 0; obs_way = 0;
        obs_fill_d = 0; obs_fill_sel = 0;
        mem_read = r; mem_write = w; mem_address = a;
        for (int cyc = 1; cyc <= 100 && !got; cyc++) begin
            #1;
            if (pmem_read && pmem_write) proto = 0;
            if (pmem_read || pmem_write) begin
                if (!busy) begin
                    busy = 1; cnt = 0; dly = $urandom_range(0, 3); cur_a = pmem_address;
                    if (pmem_write) begin wb_n++; obs_wb_a = pmem_address; end
                    else begin fill_n++; obs_fill_a = pmem_address; end
                end else if (pmem_address !== cur_a) proto = 0;
                if (cnt == dly) begin pmem_resp = 1'b1; busy = 0; end
                else cnt++;
            end
            #1;
            if (we0 && we1) proto = 0;
            if ((pmem_read || pmem_write) && mem_resp) proto = 0;
            if (pmem_resp && (we0 || we1)) begin
                obs_fill_way = we1 ? 1 : 0; obs_fill_d = d_in; obs_fill_sel = fill_sel;
            end
            if (mem_resp) begin
                got = 1; obs_lat = cyc; obs_we = {we1, we0};
                obs_d = d_in; obs_sel = fill_sel; obs_way = out_way;
            end
            @(negedge clk);
            pmem_resp = 1'b0;
        end

        checks++;
        if (!got) begin errors++; $display("FAIL resp_timeout addr=%h: no mem_resp, required one", a); end
        checks++;
        if (!proto) begin errors++; $display("FAIL protocol addr=%h: strobe/we overlap or unstable pmem_address, required clean handshake", a); end
        checks++;
        if (obs_way !== 1'(exp_way)) begin errors++; $display("FAIL out_way addr=%h: got %0d required %0d", a, obs_way, exp_way); end
        checks++;
        if (obs_we !== exp_we) begin errors++; $display("FAIL resp_we addr=%h: got %b required %b", a, obs_we, exp_we); end
        if (w) begin
            checks++;
            if (obs_d !== 1'b1 || obs_sel !== 1'b0) begin
                errors++; $display("FAIL write_ctrl addr=%h: d_in=%b fill_sel=%b required 1/0", a, obs_d, obs_sel);
            end
        end
        if (hw >= 0) begin
            checks++;
            if (obs_lat != 2 || wb_n != 0 || fill_n != 0) begin
                errors++; $display("FAIL hit_path addr=%h: lat=%0d wb=%0d fill=%0d required 2/0/0", a, obs_lat, wb_n, fill_n);
            end
        end else begin
            checks++;
            if (wb_n != int'(exp_wb) || (exp_wb && obs_wb_a !== exp_wb_a)) begin
                errors++; $display("FAIL writeback addr=%h: n=%0d a=%h required n=%0d a=%h", a, wb_n, obs_wb_a, exp_wb, exp_wb_a);
            end
            checks++;
            if (fill_n != 1 || obs_fill_a !== exp_fill_a) begin
                errors++; $display("FAIL fill addr=%h: n=%0d a=%h required 1 a=%h", a, fill_n, obs_fill_a, exp_fill_a);
            end
            checks++;
            if (obs_fill_way != vic || obs_fill_d !== 1'b0 || obs_fill_sel !== 1'b1) begin
                errors++; $display("FAIL fill_we addr=%h: way=%0d d_in=%b sel=%b required way=%0d 0/1", a, obs_fill_way, obs_fill_d, obs_fill_sel, vic);
            end
        end

        if (hw < 0) begin
            mv[vic][s] = 1; mt[vic][s] = t; md[vic][s] = 0; hw = vic; m_miss++;
        end else m_hit++;
        if (w) md[hw][s] = 1;
        mlru[s] = (hw == 0);
    endtask

    task automatic idle(input int n);
        mem_read = 0; mem_write = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1; mem_read = 0; mem_write = 0; pmem_resp = 0; mem_address = 16'h1230;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({mem_resp, we0, we1, d_in, fill_sel, out_way, pmem_read, pmem_write} !== 8'h00 || pmem_address !== 16'h0) begin
            errors++; $display("FAIL reset_outputs: got %b/%h required all zero", {mem_resp, we0, we1, d_in, fill_sel, out_way, pmem_read, pmem_write}, pmem_address);
        end
        checks++;
        if (way_ix !== 3'd3) begin errors++; $display("FAIL reset_way_ix: got %0d required 3", way_ix); end
        mem_address = 16'h0070;
        #1;
        checks++;
        if (way_ix !== 3'd7) begin errors++; $display("FAIL way_ix_follow: got %0d required 7", way_ix); end
        @(negedge clk);
        rst = 0;
        m_hit = 0; m_miss = 0;
        for (int i = 0; i < 8; i++) mlru[i] = 0;
        idle(2);
    endtask

    task automatic test_cold_read;
        do_access(1, 0, 16'h1230);
        checks++;
        if (obs_fill_a !== 16'h1230 || obs_fill_way != 0 || wb_n != 0) begin
            errors++; $display("FAIL cold_read: fill=%h way=%0d wb=%0d required 1230/0/0", obs_fill_a, obs_fill_way, wb_n);
        end
        idle(1);
    endtask

    task automatic test_read_hit;
        do_access(1, 0, 16'h1234);
        checks++;
        if (obs_lat != 2 || obs_way !== 1'b0) begin
            errors++; $display("FAIL read_hit: lat=%0d way=%b required 2/0", obs_lat, obs_way);
        end
        idle(1);
    endtask

    task automatic test_write_hit;
        do_access(0, 1, 16'h1238);
        checks++;
        if (obs_we !== 2'b01 || obs_d !== 1'b1 || obs_sel !== 1'b0) begin
            errors++; $display("FAIL write_hit: we=%b d_in=%b sel=%b required 01/1/0", obs_we, obs_d, obs_sel);
        end
    endtask

`ifdef L1_PERF_CNT_EN
    task automatic test_perf;
        do_access(1, 0, 16'h123C);
        idle(1);
        checks++;
        if (miss_count !== 16'd1 || hit_count !== 16'd3) begin
            errors++; $display("FAIL perf_counts: miss=%0d hit=%0d required 1/3", miss_count, hit_count);
        end
    endtask
`endif

    task automatic test_writeback;
        do_access(1, 0, 16'h5030);
        do_access(1, 0, 16'hA030);
        checks++;
        if (obs_wb_a !== 16'h1230 || obs_fill_a !== 16'hA030 || obs_fill_way != 0) begin
            errors++; $display("FAIL writeback_seq: wb=%h fill=%h way=%0d required 1230/A030/0", obs_wb_a, obs_fill_a, obs_fill_way);
        end
    endtask

    task automatic test_reset_mid_wb;
        bit seen;
        bit quiet;
        do_access(0, 1, 16'h5038);
        do_access(0, 1, 16'hA038);
        mem_read = 1; mem_write = 0; mem_address = 16'h7030;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #1;
            if (pmem_write) seen = 1;
        end
        checks++;
        if (!seen || pmem_address !== 16'h5030) begin
            errors++; $display("FAIL wb_entry: seen=%b addr=%h required 1/5030", seen, pmem_address);
        end
        rst = 1;
        @(negedge clk); #1;
        checks++;
        if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || mem_resp !== 1'b0 || we0 !== 1'b0 || we1 !== 1'b0) begin
            errors++; $display("FAIL reset_mid_wb: pw=%b pr=%b resp=%b we=%b%b required 0", pmem_write, pmem_read, mem_resp, we1, we0);
        end
        rst = 0; mem_read = 0;
        m_hit = 0; m_miss = 0;
        for (int i = 0; i < 8; i++) mlru[i] = 0;
        quiet = 1;
        repeat (3) begin
            @(negedge clk); #1;
            if (pmem_write || pmem_read || mem_resp) quiet = 0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL post_reset_idle: activity seen, required none"); end
        @(negedge clk);
        do_access(1, 0, 16'h7030);
        checks++;
        if (obs_wb_a !== 16'hA030 || obs_fill_way != 0) begin
            errors++; $display("FAIL lru_cleared: wb=%h way=%0d required A030/0", obs_wb_a, obs_fill_way);
        end
    endtask

    task automatic test_random;
        logic [8:0]  pool [5];
        logic [15:0] a;
        int          op;
        pool[0] = 9'h024; pool[1] = 9'h0A0; pool[2] = 9'h140; pool[3] = 9'h0E0; pool[4] = 9'h1FF;
        for (int n = 0; n < 300; n++) begin
            a  = {pool[$urandom_range(0, 4)], 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            op = $urandom_range(0, 2);
            do_access(op != 1, op != 0, a);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
    endtask

    task automatic test_final_state;
        bit ok;
        for (int s = 0; s < 8; s++) begin
            ok = (wv0[s] == mv[0][s]) && (wv1[s] == mv[1][s]);
            if (mv[0][s]) ok = ok && (wt0[s] == mt[0][s]) && (wd0[s] == md[0][s]);
            if (mv[1][s]) ok = ok && (wt1[s] == mt[1][s]) && (wd1[s] == md[1][s]);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL way_state set=%0d: v=%b%b t=%h/%h d=%b%b required v=%b%b t=%h/%h d=%b%b", s,
                    wv1[s], wv0[s], wt1[s], wt0[s], wd1[s], wd0[s], mv[1][s], mv[0][s], mt[1][s], mt[0][s], md[1][s], md[0][s]);
            end
        end
`ifdef L1_PERF_CNT_EN
        checks++;
        if (hit_count !== 16'(m_hit) || miss_count !== 16'(m_miss)) begin
            errors++; $display("FAIL perf_final: hit=%0d miss=%0d required %0d/%0d", hit_count, miss_count, m_hit, m_miss);
        end
`endif
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            wt0[i] = '0; wt1[i] = '0; mlru[i] = 0;
            for (int k = 0; k < 2; k++) begin mv[k][i] = 0; md[k][i] = 0; mt[k][i] = '0; end
        end
        m_hit = 0; m_miss = 0;
        test_reset;
        test_cold_read;
        test_read_hit;
        test_write_hit;
`ifdef L1_PERF_CNT_EN
        test_perf;
`endif
        test_writeback;
        test_reset_mid_wb;
        test_random;
        test_final_state;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
